// File: rtl/axi_master_pkg.sv
// Shared types and constants for the AXI master write engine.
package axi_master_pkg;

  localparam int unsigned LEN_W = 8;
  localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } w_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead read data; push/pop ignored when full/empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_master_write_engine.sv
// AXI4 master write engine: local cmd/data/rsp streams to AW/W/B with several bursts in flight.
module axi_master_write_engine
  import axi_master_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned ID_W            = 12,
  parameter int unsigned AXI_ID          = 0,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic [7:0]                       cmd_len,
  input  logic [2:0]                       cmd_size,
  input  logic [1:0]                       cmd_burst,
  input  logic                             wd_valid,
  output logic                             wd_ready,
  input  logic [DATA_W-1:0]                wd_data,
  input  logic [DATA_W/8-1:0]              wd_strb,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [1:0]                       rsp_resp,
  output logic [ID_W-1:0]                  m_axi_awid,
  output logic [ADDR_W-1:0]                m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic                             m_axi_awlock,
  output logic [3:0]                       m_axi_awcache,
  output logic [2:0]                       m_axi_awprot,
  output logic [3:0]                       m_axi_awqos,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [ID_W-1:0]                  m_axi_wid,
  output logic [DATA_W-1:0]                m_axi_wdata,
  output logic [DATA_W/8-1:0]              m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  input  logic [ID_W-1:0]                  m_axi_bid,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err_sticky
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic             cmd_fire;
  logic             aw_fire;
  logic             w_fire;
  logic             b_fire;
  logic             len_pop;
  logic [LEN_W-1:0] len_dout;
  logic             len_empty;
  logic             len_full;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  w_state_e         w_state;
  w_state_e         w_state_nxt;
  logic             unused_bid;

  assign unused_bid = ^m_axi_bid;

  assign cmd_ready = !m_axi_awvalid && (outstanding < OUT_W'(MAX_OUTSTANDING)) && !len_full;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign aw_fire   = m_axi_awvalid && m_axi_awready;
  assign w_fire    = m_axi_wvalid && m_axi_wready;

  // B is only acknowledged while a burst is actually in flight
  assign m_axi_bready = rsp_ready && (outstanding != '0);
  assign rsp_valid    = m_axi_bvalid && (outstanding != '0);
  assign rsp_resp     = m_axi_bresp;
  assign b_fire       = m_axi_bvalid && m_axi_bready;

  assign m_axi_awid    = ID_W'(AXI_ID);
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AWCACHE_DEFAULT;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_wid     = ID_W'(AXI_ID);
  assign m_axi_wdata   = wd_data;
  assign m_axi_wstrb   = wd_strb;

  sync_fifo #(.WIDTH(LEN_W), .DEPTH(MAX_OUTSTANDING)) u_len_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_fire),
    .din   (cmd_len),
    .pop   (len_pop),
    .dout  (len_dout),
    .empty (len_empty),
    .full  (len_full)
  );

  // AW channel registers, held stable until awready
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awsize  <= '0;
      m_axi_awburst <= '0;
    end else if (cmd_fire) begin
      m_axi_awvalid <= 1'b1;
      m_axi_awaddr  <= cmd_addr;
      m_axi_awlen   <= cmd_len;
      m_axi_awsize  <= cmd_size;
      m_axi_awburst <= cmd_burst;
    end else if (aw_fire) begin
      m_axi_awvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      err_sticky  <= 1'b0;
    end else begin
      case ({cmd_fire, b_fire})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (b_fire && (resp_e'(m_axi_bresp) != RESP_OKAY)) err_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  // W FSM: pops one length per burst, chains bursts back to back
  always_comb begin
    w_state_nxt  = w_state;
    len_pop      = 1'b0;
    m_axi_wvalid = 1'b0;
    wd_ready     = 1'b0;
    m_axi_wlast  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (!len_empty) begin
          len_pop     = 1'b1;
          w_state_nxt = W_BURST;
        end
      end
      W_BURST: begin
        m_axi_wvalid = wd_valid;
        wd_ready     = m_axi_wready;
        m_axi_wlast  = (beat_cnt == len_q);
        if (wd_valid && m_axi_wready && (beat_cnt == len_q)) begin
          if (!len_empty) len_pop = 1'b1;
          else            w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      beat_cnt <= '0;
    end else if (len_pop) begin
      len_q    <= len_dout;
      beat_cnt <= '0;
    end else if (w_fire) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_master_write_engine.sv
// Directed self-checking bench for axi_master_write_engine.
module tb_axi_master_write_engine;
  import axi_master_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 12;
  localparam int unsigned MAXO   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic [2:0]        cmd_size;
  logic [1:0]        cmd_burst;
  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic [7:0]        wd_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_resp;
  logic [ID_W-1:0]   m_axi_awid;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic              m_axi_awlock;
  logic [3:0]        m_axi_awcache;
  logic [2:0]        m_axi_awprot;
  logic [3:0]        m_axi_awqos;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [ID_W-1:0]   m_axi_wid;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [7:0]        m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [ID_W-1:0]   m_axi_bid;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic [2:0]        outstanding;
  logic              err_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_master_write_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(0), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .outstanding(outstanding), .err_sticky(err_sticky)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = 3'd3; cmd_burst = BURST_INCR;
    wd_valid = 1'b0; wd_data = '0; wd_strb = 8'hFF; rsp_ready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bid = '0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    wd_valid = 1'b1; m_axi_bvalid = 1'b1; rsp_ready = 1'b1;
    step(); step(); #1;
    n_checks++;
    if ({m_axi_awvalid, m_axi_wvalid, wd_ready, m_axi_wlast} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_valids: got %b expected 0000", {m_axi_awvalid, m_axi_wvalid, wd_ready, m_axi_wlast});
    end
    n_checks++;
    if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    n_checks++;
    if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_sticky); end
    n_checks++;
    if ({rsp_valid, m_axi_bready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_spurious_b: got %b expected 00", {rsp_valid, m_axi_bready});
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_checks++;
    if ({m_axi_awcache, m_axi_awlock, m_axi_awprot, m_axi_awqos, m_axi_awaddr} !== {4'b0011, 1'b0, 3'd0, 4'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_aw_fields: got cache=%h addr=%h expected cache=3 addr=0", m_axi_awcache, m_axi_awaddr);
    end
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_single();
    m_axi_awready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 32'h1000; cmd_len = 8'd0; cmd_size = 3'd3; cmd_burst = BURST_INCR;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL single_cmd_ready: got %b expected 1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    wd_valid = 1'b1; wd_data = 64'h1122_3344_5566_7788; wd_strb = 8'hF0; m_axi_wready = 1'b1;
    #1;
    n_checks++;
    if ({m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst} !== {1'b1, 32'h1000, 8'd0, 3'd3, 2'b01}) begin
      n_fail++;
      $display("FAIL single_aw: got v=%b addr=%h len=%0d size=%0d burst=%0d expected v=1 addr=1000 len=0 size=3 burst=1",
               m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst);
    end
    n_checks++;
    if ({outstanding, m_axi_wvalid} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL single_outst_idle: got outst=%0d wvalid=%b expected 1 0", outstanding, m_axi_wvalid);
    end
    step(); #1;
    n_checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, wd_ready, m_axi_wdata, m_axi_wstrb} !==
        {1'b0, 1'b1, 1'b1, 1'b1, 64'h1122_3344_5566_7788, 8'hF0}) begin
      n_fail++;
      $display("FAIL single_wbeat: got awv=%b wv=%b wl=%b rdy=%b d=%h s=%h expected 0 1 1 1 1122334455667788 f0",
               m_axi_awvalid, m_axi_wvalid, m_axi_wlast, wd_ready, m_axi_wdata, m_axi_wstrb);
    end
    step();
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00; rsp_ready = 1'b1;
    #1;
    n_checks++;
    if ({m_axi_wvalid, rsp_valid, m_axi_bready, rsp_resp} !== {1'b0, 1'b1, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL single_b: got wv=%b rv=%b br=%b resp=%b expected 0 1 1 00", m_axi_wvalid, rsp_valid, m_axi_bready, rsp_resp);
    end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if ({outstanding, err_sticky} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL single_done: got outst=%0d err=%b expected 0 0", outstanding, err_sticky);
    end
  endtask

  task automatic test_burst_toggle();
    int beats;
    logic [63:0] exp_d;
    step();
    m_axi_awready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 32'h2000; cmd_len = 8'd7;
    step();
    cmd_valid = 1'b0;
    wd_valid = 1'b1;
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      m_axi_wready = 1'(c % 2);
      exp_d = 64'hD0D0_0000_0000_0000 | 64'(beats);
      wd_data = exp_d;
      #1;
      if (m_axi_wvalid && m_axi_wready) begin
        n_checks++;
        if ({m_axi_wdata, m_axi_wlast} !== {exp_d, (beats == 7)}) begin
          n_fail++;
          $display("FAIL burst_beat%0d: got d=%h last=%b expected d=%h last=%b", beats, m_axi_wdata, m_axi_wlast, exp_d, (beats == 7));
        end
        beats++;
      end
      step();
    end
    m_axi_wready = 1'b1;
    #1;
    n_checks++;
    if (beats !== 8) begin n_fail++; $display("FAIL burst_count: got %0d expected 8", beats); end
    n_checks++;
    if (m_axi_wvalid !== 1'b0) begin n_fail++; $display("FAIL burst_idle_after: got %b expected 0", m_axi_wvalid); end
    m_axi_bvalid = 1'b1; rsp_ready = 1'b1;
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (outstanding !== 3'd0) begin n_fail++; $display("FAIL burst_outst: got %0d expected 0", outstanding); end
  endtask

  task automatic test_full();
    int accepted;
    int stall_bad;
    int wbeats;
    step();
    m_axi_awready = 1'b1; cmd_len = 8'd0; cmd_valid = 1'b1;
    accepted = 0;
    for (int c = 0; c < 30 && accepted < 4; c++) begin
      cmd_addr = 32'h3000 + 32'(accepted) * 32'h100;
      #1;
      if (cmd_ready) accepted++;
      step();
    end
    cmd_addr = 32'h3400;
    #1;
    n_checks++;
    if ({32'(accepted), outstanding, cmd_ready} !== {32'd4, 3'd4, 1'b0}) begin
      n_fail++; $display("FAIL full_state: got acc=%0d outst=%0d rdy=%b expected 4 4 0", accepted, outstanding, cmd_ready);
    end
    stall_bad = 0;
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      if (cmd_ready) stall_bad++;
    end
    n_checks++;
    if (stall_bad !== 0) begin n_fail++; $display("FAIL full_stall: got %0d ready cycles expected 0", stall_bad); end
    step();
    m_axi_bvalid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_checks++;
    if ({m_axi_bready, cmd_ready} !== 2'b10) begin
      n_fail++; $display("FAIL full_b_cycle: got bready=%b rdy=%b expected 1 0", m_axi_bready, cmd_ready);
    end
    step();
    m_axi_bvalid = 1'b0; rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, outstanding} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL full_after_b: got rdy=%b outst=%0d expected 1 3", cmd_ready, outstanding);
    end
    step();
    cmd_valid = 1'b0;
    #1;
    n_checks++;
    if ({outstanding, m_axi_awvalid, m_axi_awaddr} !== {3'd4, 1'b1, 32'h3400}) begin
      n_fail++;
      $display("FAIL full_fifth: got outst=%0d awv=%b addr=%h expected 4 1 3400", outstanding, m_axi_awvalid, m_axi_awaddr);
    end
    wd_valid = 1'b1; m_axi_wready = 1'b1;
    wbeats = 0;
    for (int c = 0; c < 12 && wbeats < 5; c++) begin
      #1;
      if (m_axi_wvalid && m_axi_wready) wbeats++;
      step();
    end
    n_checks++;
    if (wbeats !== 5) begin n_fail++; $display("FAIL full_wdrain: got %0d beats expected 5", wbeats); end
    m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    m_axi_bvalid = 1'b0; rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({outstanding, m_axi_wvalid} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL full_drained: got outst=%0d wv=%b expected 0 0", outstanding, m_axi_wvalid);
    end
    idle_inputs();
  endtask

  task automatic test_aw_stall();
    int aw_bad;
    int acc_bad;
    int wbeats;
    int last_idx;
    step();
    m_axi_awready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h4000; cmd_len = 8'd3; cmd_size = 3'd2; cmd_burst = BURST_WRAP;
    step();
    cmd_addr = 32'h5000; cmd_len = 8'd9; cmd_size = 3'd3; cmd_burst = BURST_INCR;
    wd_valid = 1'b1; m_axi_wready = 1'b1;
    aw_bad = 0; acc_bad = 0; wbeats = 0; last_idx = -1;
    for (int c = 0; c < 6; c++) begin
      wd_data = 64'(c);
      #1;
      if ({m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst} !== {1'b1, 32'h4000, 8'd3, 3'd2, 2'b10})
        aw_bad++;
      if (cmd_ready) acc_bad++;
      if (m_axi_wvalid && m_axi_wready) begin
        if (m_axi_wlast) last_idx = wbeats;
        wbeats++;
      end
      step();
    end
    n_checks++;
    if (aw_bad !== 0) begin n_fail++; $display("FAIL stall_aw_stable: got %0d unstable cycles expected 0", aw_bad); end
    n_checks++;
    if (acc_bad !== 0) begin n_fail++; $display("FAIL stall_no_accept: got %0d ready cycles expected 0", acc_bad); end
    n_checks++;
    if ({32'(wbeats), 32'(last_idx)} !== {32'd4, 32'd3}) begin
      n_fail++; $display("FAIL stall_wburst: got beats=%0d last_at=%0d expected 4 3", wbeats, last_idx);
    end
    cmd_valid = 1'b0; wd_valid = 1'b0; m_axi_awready = 1'b1;
    #1;
    n_checks++;
    if (outstanding !== 3'd1) begin n_fail++; $display("FAIL stall_outst: got %0d expected 1", outstanding); end
    step(); #1;
    n_checks++;
    if (m_axi_awvalid !== 1'b0) begin n_fail++; $display("FAIL stall_aw_clear: got %b expected 0", m_axi_awvalid); end
    m_axi_bvalid = 1'b1; rsp_ready = 1'b1;
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (outstanding !== 3'd0) begin n_fail++; $display("FAIL stall_done: got %0d expected 0", outstanding); end
  endtask

  task automatic test_err();
    int accepted;
    logic [1:0] exp_r;
    step();
    m_axi_awready = 1'b1; wd_valid = 1'b1; m_axi_wready = 1'b1;
    cmd_len = 8'd0; cmd_valid = 1'b1;
    accepted = 0;
    for (int c = 0; c < 20 && accepted < 3; c++) begin
      cmd_addr = 32'h6000 + 32'(accepted) * 32'h40;
      #1;
      if (cmd_ready) accepted++;
      step();
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    wd_valid = 1'b0;
    #1;
    n_checks++;
    if ({outstanding, err_sticky} !== {3'd3, 1'b0}) begin
      n_fail++; $display("FAIL err_pre: got outst=%0d err=%b expected 3 0", outstanding, err_sticky);
    end
    for (int k = 0; k < 3; k++) begin
      exp_r = (k == 1) ? 2'b10 : 2'b00;
      m_axi_bvalid = 1'b1; m_axi_bresp = exp_r; rsp_ready = 1'b1;
      #1;
      n_checks++;
      if ({rsp_valid, rsp_resp} !== {1'b1, exp_r}) begin
        n_fail++; $display("FAIL err_rsp%0d: got v=%b resp=%b expected 1 %b", k, rsp_valid, rsp_resp, exp_r);
      end
      step(); #1;
      n_checks++;
      if (err_sticky !== (k >= 1)) begin
        n_fail++; $display("FAIL err_sticky%0d: got %b expected %b", k, err_sticky, (k >= 1));
      end
    end
    idle_inputs();
    #1;
    n_checks++;
    if ({outstanding, err_sticky} !== {3'd0, 1'b1}) begin
      n_fail++; $display("FAIL err_post: got outst=%0d err=%b expected 0 1", outstanding, err_sticky);
    end
  endtask

  task automatic test_rst_mid();
    int beats;
    int last_idx;
    step();
    m_axi_awready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h7000; cmd_len = 8'd7;
    step();
    cmd_valid = 1'b0; wd_valid = 1'b1; m_axi_wready = 1'b1;
    beats = 0;
    for (int c = 0; c < 10 && beats < 3; c++) begin
      wd_data = 64'(beats);
      #1;
      if (m_axi_wvalid && m_axi_wready) beats++;
      step();
    end
    #1;
    n_checks++;
    if ({32'(beats), m_axi_wvalid, m_axi_wlast, m_axi_awvalid} !== {32'd3, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_pre: got beats=%0d wv=%b wl=%b awv=%b expected 3 1 0 1", beats, m_axi_wvalid, m_axi_wlast, m_axi_awvalid);
    end
    rst = 1'b1;
    step();
    m_axi_bvalid = 1'b1;
    #1;
    n_checks++;
    if ({m_axi_awvalid, m_axi_wvalid, rsp_valid, outstanding, err_sticky} !== {1'b0, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid: got awv=%b wv=%b rv=%b outst=%0d err=%b expected 0 0 0 0 0",
               m_axi_awvalid, m_axi_wvalid, rsp_valid, outstanding, err_sticky);
    end
    rst = 1'b0;
    idle_inputs();
    step();
    m_axi_awready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 32'h8000; cmd_len = 8'd1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_new_ready: got %b expected 1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    #1;
    n_checks++;
    if ({m_axi_awvalid, m_axi_awaddr, m_axi_awlen, outstanding} !== {1'b1, 32'h8000, 8'd1, 3'd1}) begin
      n_fail++;
      $display("FAIL rst_new_aw: got awv=%b addr=%h len=%0d outst=%0d expected 1 8000 1 1",
               m_axi_awvalid, m_axi_awaddr, m_axi_awlen, outstanding);
    end
    wd_valid = 1'b1; m_axi_wready = 1'b1;
    beats = 0; last_idx = -1;
    for (int c = 0; c < 10 && beats < 2; c++) begin
      #1;
      if (m_axi_wvalid && m_axi_wready) begin
        if (m_axi_wlast) last_idx = beats;
        beats++;
      end
      step();
    end
    n_checks++;
    if ({32'(beats), 32'(last_idx)} !== {32'd2, 32'd1}) begin
      n_fail++; $display("FAIL rst_new_w: got beats=%0d last_at=%0d expected 2 1", beats, last_idx);
    end
    wd_valid = 1'b0;
    m_axi_bvalid = 1'b1; rsp_ready = 1'b1;
    step();
    idle_inputs();
    #1;
    n_checks++;
    if ({outstanding, err_sticky} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL rst_new_done: got outst=%0d err=%b expected 0 0", outstanding, err_sticky);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_burst_toggle();
    test_full();
    test_aw_stall();
    test_err();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
